// File: rtl/gray_to_bin_pipe.sv
// Two-stage valid/ready pipeline converting Gray-coded words back to binary.
// Define GRAY_STEP_CHECK_EN to build the Gray step checker; otherwise step_err and err_count read 0.
module gray_to_bin_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count
);

  // Prefix XOR from the MSB down turns a Gray word into its binary value.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = {WIDTH{1'b0}};
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_bin_q, s2_bin_d;
  logic             s2_err_q, s2_err_d;
  logic             adv1, adv2, move12;
  logic             chk_err;

  // Advance rules: a stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv2   = !s2_valid_q || out_ready;
    adv1   = !s1_valid_q || adv2;
    move12 = s1_valid_q && adv2;
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_gray_d  = s1_gray_q;
    s2_valid_d = s2_valid_q;
    s2_bin_d   = s2_bin_q;
    s2_err_d   = s2_err_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_gray_d = gray_in;
      end else begin
        s1_gray_d = s1_gray_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    // Result registers only load on a real word so bin_out/step_err hold while idle or stalled.
    if (move12) begin
      s2_bin_d = gray2bin(s1_gray_q);
      s2_err_d = chk_err;
    end else begin
      s2_bin_d = s2_bin_q;
      s2_err_d = s2_err_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= {WIDTH{1'b0}};
      s2_valid_q <= 1'b0;
      s2_bin_q   <= {WIDTH{1'b0}};
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_gray_q  <= s1_gray_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
      s2_err_q   <= s2_err_d;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  typedef enum logic [0:0] {
    NO_REF = 1'b0,
    TRACK  = 1'b1
  } chk_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A legal step differs in exactly one bit: nonzero and a power of two.
  function automatic logic single_step(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] xm1;
    xm1 = x - {{(WIDTH-1){1'b0}}, 1'b1};
    return (x != {WIDTH{1'b0}}) && ((x & xm1) == {WIDTH{1'b0}});
  endfunction

  chk_state_t       chk_state_q, chk_state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Checker next-state; the reference tracks every word moving into stage 2.
  always_comb begin
    chk_state_d = chk_state_q;
    ref_d       = ref_q;
    chk_err     = 1'b0;
    case (chk_state_q)
      NO_REF: begin
        chk_err = 1'b0;
        if (move12) begin
          ref_d       = s1_gray_q;
          chk_state_d = TRACK;
        end else begin
          ref_d       = ref_q;
          chk_state_d = NO_REF;
        end
      end
      TRACK: begin
        chk_err = !single_step(s1_gray_q ^ ref_q);
        if (move12) begin
          ref_d = s1_gray_q;
        end else begin
          ref_d = ref_q;
        end
      end
      default: begin
        chk_state_d = NO_REF;
      end
    endcase
  end

  // Saturating error count, stepped on each delivered result flagged as a bad step.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Checker state, reference word and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_state_q <= NO_REF;
      ref_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      chk_state_q <= chk_state_d;
      ref_q       <= ref_d;
      cnt_q       <= cnt_d;
    end
  end

  assign err_count = cnt_q;
`else
  assign chk_err   = 1'b0;
  assign err_count = {CNT_W{1'b0}};
`endif

  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;
  assign bin_out   = s2_bin_q;
  assign step_err  = s2_err_q;

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Bench for gray_to_bin_pipe: transaction-level scoreboard model plus directed vectors.
module tb_gray_to_bin_pipe;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] gray_in;
  logic       in_ready, out_valid, step_err;
  logic [3:0] bin_out;
  logic [7:0] err_count;
  logic       in_ready2, out_valid2, step_err2;
  logic [3:0] bin_out2;
  logic [1:0] err_count2;

  always #5 clk = ~clk;

  gray_to_bin_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .gray_in(gray_in),
    .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out),
    .step_err(step_err), .err_count(err_count)
  );

  gray_to_bin_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .gray_in(gray_in),
    .out_valid(out_valid2), .out_ready(out_ready), .bin_out(bin_out2),
    .step_err(step_err2), .err_count(err_count2)
  );

  typedef struct {
    logic [3:0] bin;
    logic       err;
    int         acc_cyc;
  } item_t;

  item_t      q[$];
  logic [3:0] out_log[$];
  int         total = 0, bad = 0;
  int         cyc = 0, acc_n = 0;
  bit         have_ref = 1'b0;
  logic [3:0] ref_g = 4'd0;
  int         cnt8 = 0, cnt2 = 0;

  // Binary value of a Gray word: XOR of all right shifts of it.
  function automatic logic [3:0] model_bin(input logic [3:0] g);
    logic [3:0] b;
    b = 4'd0;
    for (int k = 0; k < 4; k++) b = b ^ (g >> k);
    return b;
  endfunction

  // Oldest word is visible once the edge after its acceptance has passed.
  function automatic bit exp_ov();
    return (q.size() > 0) && (q[0].acc_cyc <= cyc - 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge.
  always @(posedge clk) begin
    bit    ov, ir;
    item_t it;
    if (rst) begin
      q.delete();
      have_ref = 1'b0;
      cnt8 = 0;
      cnt2 = 0;
    end else begin
      ov = exp_ov();
      ir = (q.size() < 2) || out_ready;
      if (ov && out_ready) begin
        if (q[0].err) begin
          if (cnt8 < 255) cnt8++;
          if (cnt2 < 3) cnt2++;
        end
        out_log.push_back(bin_out);
        void'(q.pop_front());
      end
      if (in_valid && ir) begin
        it.bin     = model_bin(gray_in);
        it.err     = CHK && have_ref && ($countones(gray_in ^ ref_g) != 1);
        it.acc_cyc = cyc;
        have_ref   = 1'b1;
        ref_g      = gray_in;
        q.push_back(it);
        acc_n++;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst && cyc > 0) begin
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("out_valid", out_valid, exp_ov());
      check("out_valid2", out_valid2, exp_ov());
      if (exp_ov()) begin
        check("bin_out", bin_out, q[0].bin);
        check("step_err", step_err, q[0].err);
        check("bin_out2", bin_out2, q[0].bin);
      end
      check("err_count", err_count, cnt8);
      check("err_count2", err_count2, cnt2);
    end
  end

  task automatic send(input logic [3:0] g);
    int n0, t;
    n0 = acc_n;
    t = 0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    gray_in  = g;
    while (acc_n == n0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (acc_n == n0) begin
      bad++;
      total++;
      $display("FAIL send_timeout: word %b not accepted", g);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d words left", q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n0, t;
    logic [3:0] v;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    gray_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_bin_out", bin_out, 4'd0);
    check("rst_step_err", step_err, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Short legal stream.
    out_log.delete();
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
    drain();
    check("t1_count", out_log.size(), 5);
    for (int i = 0; i < 5; i++) check("t1_bin", out_log[i], i);
    check("t1_errcnt", err_count, 8'd0);

    // Full Gray count followed by the wrap step 1000 -> 0000.
    do_reset();
    out_log.delete();
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      send(v ^ (v >> 1));
    end
    send(4'b0000);
    drain();
    check("t2_count", out_log.size(), 17);
    for (int i = 0; i < 16; i++) check("t2_bin", out_log[i], i);
    check("t2_wrap_bin", out_log[16], 4'b0000);
    check("t2_errcnt", err_count, 8'd0);

    // Backpressure: two words fill the pipe, a third waits.
    do_reset();
    out_log.delete();
    out_ready = 1'b0;
    send(4'b0001); send(4'b0011);
    @(negedge clk);
    #1;
    n0 = acc_n;
    in_valid = 1'b1;
    gray_in = 4'b0010;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("t3_in_ready_low", in_ready, 1'b0);
      check("t3_bin_hold", bin_out, 4'b0001);
    end
    out_ready = 1'b1;
    t = 0;
    while (acc_n == n0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t3_third_accepted", acc_n - n0, 1);
    in_valid = 1'b0;
    drain();
    check("t3_count", out_log.size(), 3);
    check("t3_bin0", out_log[0], 4'b0001);
    check("t3_bin1", out_log[1], 4'b0010);
    check("t3_bin2", out_log[2], 4'b0011);

    // Illegal steps: distance 2 then a repeat.
    do_reset();
    send(4'b0001); send(4'b0010); send(4'b0010);
    drain();
    check("t4_errcnt", err_count, CHK ? 8'd2 : 8'd0);

    // Five more repeats: narrow counter saturates.
    for (int i = 0; i < 5; i++) send(4'b0010);
    drain();
    check("t5_errcnt", err_count, CHK ? 8'd7 : 8'd0);
    check("t5_errcnt_sat", err_count2, CHK ? 2'd3 : 2'd0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(4'b0011); send(4'b0111);
    do_reset();
    check("t6_out_valid_cleared", out_valid, 1'b0);
    check("t6_errcnt_cleared", err_count, 8'd0);
    out_ready = 1'b1;
    out_log.delete();
    send(4'b0101);
    drain();
    check("t6_count", out_log.size(), 1);
    check("t6_bin", out_log[0], 4'b0110);
    check("t6_errcnt", err_count, 8'd0);
    check("t6_errcnt2", err_count2, 2'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
